mmio_responder: RTL
===================

// Module: mmio_responder
// PURPOSE
//  Memory-side responder for the CPU's data port (port B: address, store data, write enable, read data).
//  Addresses at or above IO_BASE are served by on-chip I/O registers:
//  - switches
//  - 7-seg/LED output register
//  - button edge capture
//  - timer
//  All other addresses pass through to the dual-port RAM.
//  Read timing matches the RAM exactly (1-cycle registered read), so loads behave identically for RAM and I/O.
// PARAMETERS
//  IO_BASE   16'hFF00  first I/O address; I/O space is IO_BASE..IO_BASE+7
//  SW_W      10        number of slide-switch inputs (1..16)
//  BTN_W     4         number of push-button inputs (1..16)
//  PRESCALE  50000     clk cycles per timer tick (>=1); tick counter width is $clog2(PRESCALE)
// PORTS
//  clk       in   1      system clock, all logic on rising edge
//  reset     in   1      synchronous, active-high reset
//  addr      in   16     CPU data address (port B address)
//  wdata     in   16     CPU store data
//  we        in   1      CPU store strobe, one cycle per store
//  ram_q     in   16     RAM port-B read data (already 1-cycle registered by the RAM)
//  ram_we    out  1      RAM port-B write enable = we & ~io_hit (combinational)
//  q         out  16     read data returned to CPU, valid 1 cycle after addr
//  sw        in   SW_W   asynchronous slide switches
//  btn       in   BTN_W  asynchronous push buttons, active-high
//  hex_out   out  16     value driven to the 7-seg display
//  timer_irq out  1      level copy of STATUS[0]
// BEHAVIOUR
//  - Decode: io_hit = (addr[15:3] == IO_BASE[15:3]); reg index = addr[2:0].
//  - io_hit is registered to sel_q alongside the read data.
//  - q = sel_q ? io_rdata_q : ram_q.
//  - Register map (R = read, W = write, W1C = write-1-to-clear):
//    - 0 SW      R    two-flop synchronised sw, zero-extended to 16 bits; writes ignored
//    - 1 HEX     R/W  hex_out register
//    - 2 BTNEDGE R/W1C sticky rising-edge flags: 2-flop sync, then edge detect against the previous synced value
//    - 3 TIMER   R/W  16-bit up counter, +1 on each prescale tick; write loads wdata and restarts the prescaler
//    - 4 CMP     R/W  compare value
//    - 5 STATUS  R/W1C bit0 = match flag, set on the tick where TIMER becomes equal to CMP
//    - 6,7       R    read 0; writes ignored
//  - Read latency: io_rdata_q is captured every cycle from the addr of that cycle, regardless of we.
//  - Read during write to the same register returns the OLD value.
//  - Reset values (one cycle after reset is asserted):
//    - q = 0, sel_q = 0, io_rdata_q = 0
//    - hex_out = 0, BTNEDGE = 0, TIMER = 0, CMP = 16'hFFFF, STATUS = 0, timer_irq = 0
//    - prescaler = 0, synchronisers = 0
//  - Reset mid-operation:
//    - a store in the reset cycle is dropped for I/O registers
//    - ram_we still follows we & ~io_hit; the RAM is not reset
//  - TIMER wraps 16'hFFFF -> 16'h0000 and keeps counting; the match flag sets only on the equality tick.
//  - Simultaneous events:
//    - BTNEDGE/STATUS set and W1C on the same bit in the same cycle: set wins
//    - TIMER write and tick in the same cycle: write wins and the prescaler restarts at 0
//    - CMP write equal to the current TIMER value: no match until the next tick that produces equality
//  - No stall or handshake: every access completes in one cycle and the block never back-pressures the CPU.
// CONFIGURATION
//  MMIO_TIMER_EN
//  - Defined: TIMER, CMP, STATUS and timer_irq are implemented as described above.
//  - Undefined:
//    - prescaler/timer logic is absent
//    - regs 3..5 read 0 and writes are ignored
//    - timer_irq is tied 0
//  - SW, HEX and BTNEDGE are unaffected either way.
// TESTING
//  1. Pass-through:
//     - stimulus: store 16'h1234 to addr 16'h0010, then load addr 16'h0010
//     - required: ram_we=1 on the store; q=ram_q one cycle after the load; ram_we=0 on a store to 16'hFF01
//  2. HEX register:
//     - stimulus: store 16'hBEEF to 16'hFF01, then load 16'hFF01
//     - required: hex_out=16'hBEEF the cycle after the store; q=16'hBEEF one cycle after the load address
//  3. Switches:
//     - stimulus: sw=10'h2A5, then load 16'hFF00 at least 3 cycles later
//     - required: q=16'h02A5
//  4. Button edge capture:
//     - stimulus: pulse btn[1] high for 5 cycles
//     - required: BTNEDGE reads 16'h0002; after storing 16'h0002 to 16'hFF02 it reads 0
//     - required: a new edge arriving in the clear cycle leaves the bit at 1
//  5. Timer (MMIO_TIMER_EN defined, PRESCALE=2):
//     - stimulus: store 0 to TIMER and 3 to CMP
//     - required: timer_irq rises 6 cycles after the TIMER write; storing 1 to 16'hFF05 clears it
//     - required: from 16'hFFFF, TIMER reads 0 after the next tick
//  6. Reset and config-off:
//     - stimulus: assert reset one cycle mid-run
//     - required: hex_out=0, q=0, timer_irq=0 the next cycle
//     - required: with MMIO_TIMER_EN undefined, loads of 16'hFF03..16'hFF05 return 0

Source files
------------

// File: rtl/mmio_responder.sv
// CPU data-port responder: I/O registers at IO_BASE..IO_BASE+7, everything else goes to the RAM.
// Define MMIO_TIMER_EN to build the TIMER/CMP/STATUS registers and timer_irq.
module mmio_responder #(
  parameter logic [15:0] IO_BASE  = 16'hFF00,
  parameter int          SW_W     = 10,
  parameter int          BTN_W    = 4,
  parameter int          PRESCALE = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      addr,
  input  logic [15:0]      wdata,
  input  logic             we,
  input  logic [15:0]      ram_q,
  output logic             ram_we,
  output logic [15:0]      q,
  input  logic [SW_W-1:0]  sw,
  input  logic [BTN_W-1:0] btn,
  output logic [15:0]      hex_out,
  output logic             timer_irq
);

  logic             w_io_hit;
  logic [2:0]       w_idx;
  logic             w_wr;
  logic             w_wr_hex;
  logic             w_wr_btn;
  logic [15:0]      w_io_rdata;
  logic [BTN_W-1:0] w_btn_rise;

  logic             r_sel_q;
  logic             r_ram_vld;
  logic [15:0]      r_io_rdata_q;
  logic [15:0]      r_hex;
  logic [SW_W-1:0]  r_sw_s1;
  logic [SW_W-1:0]  r_sw_s2;
  logic [BTN_W-1:0] r_btn_s1;
  logic [BTN_W-1:0] r_btn_s2;
  logic [BTN_W-1:0] r_btn_prev;
  logic [BTN_W-1:0] r_btn_edge;

  assign w_io_hit   = (addr[15:3] == IO_BASE[15:3]);
  assign w_idx      = addr[2:0];
  assign w_wr       = we & w_io_hit;
  assign w_wr_hex   = w_wr & (w_idx == 3'd1);
  assign w_wr_btn   = w_wr & (w_idx == 3'd2);
  assign w_btn_rise = r_btn_s2 & ~r_btn_prev;

  assign ram_we  = we & ~w_io_hit;
  assign hex_out = r_hex;
  // RAM data is masked for the cycle after reset so q reads 0 even though the RAM itself is not reset.
  assign q       = r_sel_q ? r_io_rdata_q : (r_ram_vld ? ram_q : 16'h0000);

`ifdef MMIO_TIMER_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic          w_wr_timer;
  logic          w_wr_cmp;
  logic          w_wr_status;
  logic          w_tick;
  logic [15:0]   w_timer_inc;
  logic          w_match_set;
  logic [PW-1:0] r_presc;
  logic [15:0]   r_timer;
  logic [15:0]   r_cmp;
  logic          r_match;

  assign w_wr_timer  = w_wr & (w_idx == 3'd3);
  assign w_wr_cmp    = w_wr & (w_idx == 3'd4);
  assign w_wr_status = w_wr & (w_idx == 3'd5);
  assign w_tick      = (r_presc == PW'(PRESCALE - 1));
  assign w_timer_inc = r_timer + 16'd1;
  // Match is judged on the value the tick produces, so a CMP write equal to TIMER waits for the next equality.
  assign w_match_set = w_tick & ~w_wr_timer & (w_timer_inc == r_cmp);
  assign timer_irq   = r_match;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
      r_timer <= 16'h0000;
      r_cmp   <= 16'hFFFF;
      r_match <= 1'b0;
    end else begin
      if (w_wr_timer) begin
        r_timer <= wdata;
        r_presc <= '0;
      end else if (w_tick) begin
        r_timer <= w_timer_inc;
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
      if (w_wr_cmp) r_cmp <= wdata;
      r_match <= (r_match & ~(w_wr_status & wdata[0])) | w_match_set;
    end
  end
`else
  assign timer_irq = 1'b0;
`endif

  always_comb begin
    w_io_rdata = 16'h0000;
    case (w_idx)
      3'd0: w_io_rdata = 16'(r_sw_s2);
      3'd1: w_io_rdata = r_hex;
      3'd2: w_io_rdata = 16'(r_btn_edge);
`ifdef MMIO_TIMER_EN
      3'd3: w_io_rdata = r_timer;
      3'd4: w_io_rdata = r_cmp;
      3'd5: w_io_rdata = {15'h0000, r_match};
`endif
      default: w_io_rdata = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel_q      <= 1'b0;
      r_ram_vld    <= 1'b0;
      r_io_rdata_q <= 16'h0000;
      r_hex        <= 16'h0000;
      r_sw_s1      <= '0;
      r_sw_s2      <= '0;
      r_btn_s1     <= '0;
      r_btn_s2     <= '0;
      r_btn_prev   <= '0;
      r_btn_edge   <= '0;
    end else begin
      r_sel_q      <= w_io_hit;
      r_ram_vld    <= 1'b1;
      r_io_rdata_q <= w_io_rdata;
      if (w_wr_hex) r_hex <= wdata;
      r_sw_s1      <= sw;
      r_sw_s2      <= r_sw_s1;
      r_btn_s1     <= btn;
      r_btn_s2     <= r_btn_s1;
      r_btn_prev   <= r_btn_s2;
      // A new edge in the same cycle as a write-1-to-clear keeps the flag set.
      r_btn_edge   <= (r_btn_edge & ~({BTN_W{w_wr_btn}} & wdata[BTN_W-1:0])) | w_btn_rise;
    end
  end

endmodule
